// File: rtl/dma_channel_scheduler_if.sv
// Processor/memory/IO side signals of the three-channel DMA scheduler.
// No latency of its own; it only bundles wires.
// No backpressure: hreq/hack and dreq/dack carry all of the handshaking.
interface dma_channel_scheduler_if #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int CW = 8
);
   logic          cfg_we;
   logic [1:0]    cfg_ch;
   logic [AW-1:0] cfg_src;
   logic [AW-1:0] cfg_dst;
   logic [CW-1:0] cfg_cnt;
   logic          dreq1;
   logic          dreq2;
   logic          hack;
   logic          hreq;
   logic          dack1;
   logic          dack2;
   logic [AW-1:0] ab;
   logic [DW-1:0] db_in;
   logic [DW-1:0] db_out;
   logic          rd_mem;
   logic          wr_mem;
   logic          rd_io;
   logic          wr_io;
   logic          en_mem;
   logic          en_io1;
   logic          en_io2;
   logic          busy;
   logic          done;
   logic [1:0]    active_ch;

   // scheduler side
   modport master (
      input  cfg_we, cfg_ch, cfg_src, cfg_dst, cfg_cnt, dreq1, dreq2, hack, db_in,
      output hreq, dack1, dack2, ab, db_out, rd_mem, wr_mem, rd_io, wr_io,
             en_mem, en_io1, en_io2, busy, done, active_ch
   );

   // processor, memory and IO side
   modport slave (
      output cfg_we, cfg_ch, cfg_src, cfg_dst, cfg_cnt, dreq1, dreq2, hack, db_in,
      input  hreq, dack1, dack2, ab, db_out, rd_mem, wr_mem, rd_io, wr_io,
             en_mem, en_io1, en_io2, busy, done, active_ch
   );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Round-robin DMA scheduler for three channels sharing one 8-bit address/data bus.
// Bus requested one cycle after arbitration; grant, then 2 cycles per word (RD, WR).
// Stalls in REQ until hack; gives the bus back as soon as hack drops after a completed word.
module dma_channel_scheduler #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int CW = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   dma_channel_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_GRANT, S_RD, S_WR, S_DONE, S_RELEASE
   } state_t;

   state_t state_q;

   // Per-channel registers indexed by channel number; entry 0 is never loaded.
   logic [AW-1:0] src_q [0:3];
   logic [AW-1:0] dst_q [0:3];
   logic [CW-1:0] cnt_q [0:3];

   logic [1:0]    rr_ptr;      // channel that gets first look at the next arbitration
   logic [1:0]    win;
   logic [3:0]    elig;
   logic [2:0]    arb_sum;
   logic [AW-1:0] cur_src;
   logic [AW-1:0] cur_dst;
   logic [CW-1:0] cur_cnt;
   logic          src_is_io;
   logic          dst_is_io;

   assign cur_src   = src_q[bus.active_ch];
   assign cur_dst   = dst_q[bus.active_ch];
   assign cur_cnt   = cnt_q[bus.active_ch];
   // ch2 reads from IO2, ch1 writes to IO1; everything else is memory.
   assign src_is_io = (bus.active_ch == 2'd2);
   assign dst_is_io = (bus.active_ch == 2'd1);

   // A channel is armed while it has words left; ch3 needs no device request.
   always_comb begin
      elig    = '0;
      elig[1] = (cnt_q[1] != '0) && bus.dreq1;
      elig[2] = (cnt_q[2] != '0) && bus.dreq2;
      elig[3] = (cnt_q[3] != '0);
   end

   // Round-robin pick: scan from rr_ptr upward, lowest offset wins.
   always_comb begin
      win     = 2'd0;
      arb_sum = '0;
      for (int i = 2; i >= 0; i--) begin
         arb_sum = {1'b0, rr_ptr} + 3'(i);
         if (arb_sum > 3'd3) arb_sum = arb_sum - 3'd3;
         if (elig[arb_sum[1:0]]) win = arb_sum[1:0];
      end
   end

   // Channel register bank: processor writes, and per-word stepping of the owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) begin
            src_q[c] <= '0;
            dst_q[c] <= '0;
            cnt_q[c] <= '0;
         end
      end else begin
         for (int c = 1; c < 4; c++) begin
            if (bus.cfg_we && bus.cfg_ch == 2'(c) && bus.active_ch != 2'(c)) begin
               src_q[c] <= bus.cfg_src;
               dst_q[c] <= bus.cfg_dst;
               cnt_q[c] <= bus.cfg_cnt;
            end else if (state_q == S_WR && bus.active_ch == 2'(c)) begin
               src_q[c] <= src_q[c] + AW'(1);
               dst_q[c] <= dst_q[c] + AW'(1);
               cnt_q[c] <= cnt_q[c] - CW'(1);
            end
         end
      end
   end

   // Sequencer with registered bus outputs; strobes and bus values are pulses by default.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         rr_ptr        <= 2'd1;
         bus.hreq      <= 1'b0;
         bus.dack1     <= 1'b0;
         bus.dack2     <= 1'b0;
         bus.ab        <= '0;
         bus.db_out    <= '0;
         bus.rd_mem    <= 1'b0;
         bus.wr_mem    <= 1'b0;
         bus.rd_io     <= 1'b0;
         bus.wr_io     <= 1'b0;
         bus.en_mem    <= 1'b0;
         bus.en_io1    <= 1'b0;
         bus.en_io2    <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.active_ch <= 2'd0;
      end else begin
         bus.dack1  <= 1'b0;
         bus.dack2  <= 1'b0;
         bus.done   <= 1'b0;
         bus.ab     <= '0;
         bus.db_out <= '0;
         bus.rd_mem <= 1'b0;
         bus.wr_mem <= 1'b0;
         bus.rd_io  <= 1'b0;
         bus.wr_io  <= 1'b0;
         bus.en_mem <= 1'b0;
         bus.en_io1 <= 1'b0;
         bus.en_io2 <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win != 2'd0) begin
                  state_q       <= S_REQ;
                  bus.hreq      <= 1'b1;
                  bus.busy      <= 1'b1;
                  bus.active_ch <= win;
               end
            end
            S_REQ: begin
               if (bus.hack) begin
                  state_q   <= S_GRANT;
                  bus.dack1 <= (bus.active_ch == 2'd1);
                  bus.dack2 <= (bus.active_ch == 2'd2);
               end
            end
            S_GRANT: begin
               state_q <= S_RD;
               bus.ab  <= cur_src;
               {bus.rd_mem, bus.en_mem, bus.rd_io, bus.en_io2} <=
                  {!src_is_io, !src_is_io, src_is_io, src_is_io};
            end
            S_RD: begin
               // The word read this cycle goes straight into the write-data latch.
               state_q    <= S_WR;
               bus.ab     <= cur_dst;
               bus.db_out <= DW'(bus.db_in);
               {bus.wr_mem, bus.en_mem, bus.wr_io, bus.en_io1} <=
                  {!dst_is_io, !dst_is_io, dst_is_io, dst_is_io};
            end
            S_WR: begin
               if (cur_cnt == CW'(1)) begin
                  state_q  <= S_DONE;
                  bus.done <= 1'b1;
               end else if (bus.hack) begin
                  // Source register steps on this same edge, so present the next address.
                  state_q <= S_RD;
                  bus.ab  <= cur_src + AW'(1);
                  {bus.rd_mem, bus.en_mem, bus.rd_io, bus.en_io2} <=
                     {!src_is_io, !src_is_io, src_is_io, src_is_io};
               end else begin
                  state_q       <= S_RELEASE;
                  bus.hreq      <= 1'b0;
                  bus.active_ch <= 2'd0;
               end
            end
            S_DONE: begin
               state_q       <= S_RELEASE;
               bus.hreq      <= 1'b0;
               bus.active_ch <= 2'd0;
               rr_ptr        <= (bus.active_ch == 2'd3) ? 2'd1 : bus.active_ch + 2'd1;
            end
            S_RELEASE: begin
               if (!bus.hack) begin
                  state_q  <= S_IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Bench for dma_channel_scheduler: scoreboard of expected bus words plus per-scenario checks.
// Expected read/write cycles are queued when a channel is programmed and popped as they appear.
// hack follows hreq one cycle later unless a scenario takes manual control of it.
module tb_dma_channel_scheduler;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] addr;
      logic [7:0] data;
      logic [6:0] strb;   // {rd_mem, wr_mem, rd_io, wr_io, en_mem, en_io1, en_io2}
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] rd_off = 8'h00;
   bit   hack_auto = 1'b0;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   rd_cnt, wr_cnt, dack1_cnt, dack2_cnt, done_cnt;
   logic prev_done = 1'b0;
   logic hreq_after_done = 1'b1;
   ev_t  exp_q [$];

   dma_channel_scheduler_if bus ();

   dma_channel_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory/IO read data: a fixed function of the address so the bench can predict it.
   assign bus.db_in = bus.ab + rd_off;

   // Processor grants the bus one cycle after it sees a request.
   initial forever begin
      @(posedge clk);
      #1;
      if (hack_auto) bus.hack = bus.hreq;
   end

   function automatic logic [6:0] rd_strb(input logic [1:0] ch);
      return (ch == 2'd2) ? 7'b0010001 : 7'b1000100;
   endfunction

   function automatic logic [6:0] wr_strb(input logic [1:0] ch);
      return (ch == 2'd1) ? 7'b0001010 : 7'b0100100;
   endfunction

   task automatic push_block(input logic [1:0] ch, input logic [7:0] s, input logic [7:0] d,
                             input int n);
      ev_t e;
      logic [7:0] sa, da;
      for (int i = 0; i < n; i++) begin
         sa = s + 8'(i);
         da = d + 8'(i);
         e.ch = ch; e.addr = sa; e.data = 8'h00;       e.strb = rd_strb(ch);
         exp_q.push_back(e);
         e.ch = ch; e.addr = da; e.data = sa + rd_off; e.strb = wr_strb(ch);
         exp_q.push_back(e);
      end
   endtask

   // Bus monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin : monitor
      ev_t obs, expv;
      logic [6:0] strb;
      strb = {bus.rd_mem, bus.wr_mem, bus.rd_io, bus.wr_io, bus.en_mem, bus.en_io1, bus.en_io2};
      if (prev_done) hreq_after_done = bus.hreq;
      prev_done = bus.done;
      if (bus.dack1) dack1_cnt++;
      if (bus.dack2) dack2_cnt++;
      if (bus.done)  done_cnt++;
      if (strb != 7'b0) begin
         if (strb[6] | strb[4]) rd_cnt++;
         if (strb[5] | strb[3]) wr_cnt++;
         obs.ch = bus.active_ch; obs.addr = bus.ab; obs.data = bus.db_out; obs.strb = strb;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bus_unexpected: got ch=%0d ab=%0d db_out=%h strb=%b, expected no bus cycle",
                     obs.ch, obs.addr, obs.data, obs.strb);
         end else begin
            expv = exp_q.pop_front();
            if (obs !== expv) begin
               n_fail++;
               $display("FAIL bus_cycle: got ch=%0d ab=%0d db_out=%h strb=%b, expected ch=%0d ab=%0d db_out=%h strb=%b",
                        obs.ch, obs.addr, obs.data, obs.strb, expv.ch, expv.addr, expv.data, expv.strb);
            end
         end
      end else begin
         n_tests++;
         if ({bus.ab, bus.db_out} !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_bus: got ab=%h db_out=%h, expected 00 00", bus.ab, bus.db_out);
         end
      end
   end

   task automatic clr_counts();
      rd_cnt = 0; wr_cnt = 0; dack1_cnt = 0; dack2_cnt = 0; done_cnt = 0;
      hreq_after_done = 1'b1;
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] c);
      bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_src = s; bus.cfg_dst = d; bus.cfg_cnt = c;
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic wait_quiet(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_hreq(input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (bus.hreq === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [29:0] outs;
      bus.cfg_we = 1'b0; bus.cfg_ch = 2'd0; bus.cfg_src = 8'd0; bus.cfg_dst = 8'd0;
      bus.cfg_cnt = 8'd0; bus.dreq1 = 1'b0; bus.dreq2 = 1'b0; bus.hack = 1'b0;
      clr_counts();
      repeat (3) @(posedge clk);
      #1;
      outs = {bus.hreq, bus.dack1, bus.dack2, bus.ab, bus.db_out, bus.rd_mem, bus.wr_mem,
              bus.rd_io, bus.wr_io, bus.en_mem, bus.en_io1, bus.en_io2, bus.busy, bus.done,
              bus.active_ch};
      n_tests++;
      if (outs !== 30'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, expected 0", outs);
      end
      rst_n = 1'b1;
      // Zero count leaves the channel disarmed even for the always-eligible ch3.
      cfg(2'd3, 8'd5, 8'd6, 8'd0);
      repeat (6) begin
         @(negedge clk);
         n_tests++;
         if (bus.busy !== 1'b0 || bus.hreq !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cnt0: got busy=%b hreq=%b, expected 0 0", bus.busy, bus.hreq);
         end
      end
   endtask

   task automatic test_ch1();
      bit ok;
      clr_counts();
      hack_auto = 1'b1;
      rd_off = 8'h11;
      bus.dreq1 = 1'b1;
      push_block(2'd1, 8'd100, 8'd10, 3);
      cfg(2'd1, 8'd100, 8'd10, 8'd3);
      wait_quiet(100, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ch1_complete: timed out, %0d words left", exp_q.size()); end
      n_tests++;
      if (dack1_cnt !== 1 || dack2_cnt !== 0) begin
         n_fail++; $display("FAIL ch1_dack: got dack1=%0d dack2=%0d, expected 1 0", dack1_cnt, dack2_cnt);
      end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL ch1_done: got %0d pulses, expected 1", done_cnt); end
      n_tests++;
      if (hreq_after_done !== 1'b0) begin
         n_fail++; $display("FAIL ch1_hreq_drop: got hreq=%b after done, expected 0", hreq_after_done);
      end
      bus.dreq1 = 1'b0;
   endtask

   task automatic test_ch2();
      bit ok;
      clr_counts();
      rd_off = 8'h69;                       // address 55 reads back 0xA0
      bus.dreq2 = 1'b1;
      push_block(2'd2, 8'd55, 8'd100, 3);
      cfg(2'd2, 8'd55, 8'd100, 8'd3);
      wait_quiet(100, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ch2_complete: timed out, %0d words left", exp_q.size()); end
      n_tests++;
      if (dack2_cnt !== 1 || dack1_cnt !== 0) begin
         n_fail++; $display("FAIL ch2_dack: got dack1=%0d dack2=%0d, expected 0 1", dack1_cnt, dack2_cnt);
      end
      n_tests++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL ch2_done: got %0d pulses, expected 1", done_cnt); end
      bus.dreq2 = 1'b0;
   endtask

   task automatic test_ch3();
      bit ok, found;
      clr_counts();
      rd_off = 8'h07;
      push_block(2'd3, 8'd70, 8'd100, 5);
      cfg(2'd3, 8'd70, 8'd100, 8'd5);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (bus.active_ch == 2'd3) begin found = 1'b1; break; end
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL ch3_start: got active_ch=%0d, expected 3", bus.active_ch); end
      // Reprogramming the bus owner must not disturb the running block.
      cfg(2'd3, 8'd0, 8'd0, 8'd2);
      wait_quiet(100, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ch3_complete: timed out, %0d words left", exp_q.size()); end
      n_tests++;
      if (rd_cnt !== 5 || wr_cnt !== 5) begin
         n_fail++; $display("FAIL ch3_cycles: got %0d reads %0d writes, expected 5 5", rd_cnt, wr_cnt);
      end
      n_tests++;
      if (dack1_cnt + dack2_cnt !== 0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL ch3_dack_done: got dacks=%0d done=%0d, expected 0 1",
                            dack1_cnt + dack2_cnt, done_cnt);
      end
      repeat (5) @(negedge clk);
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ch3_disarmed: got busy=%b, expected 0", bus.busy); end
   endtask

   task automatic test_round_robin();
      bit ok;
      apply_reset();
      hack_auto = 1'b1;
      rd_off = 8'h00;
      for (int round = 0; round < 2; round++) begin
         clr_counts();
         bus.dreq1 = 1'b0; bus.dreq2 = 1'b0;
         cfg(2'd1, 8'd20, 8'd30, 8'd1);
         cfg(2'd2, 8'd40, 8'd50, 8'd1);
         push_block(2'd1, 8'd20, 8'd30, 1);
         push_block(2'd2, 8'd40, 8'd50, 1);
         bus.dreq1 = 1'b1; bus.dreq2 = 1'b1;
         wait_quiet(100, ok);
         n_tests++;
         if (!ok || done_cnt !== 2) begin
            n_fail++; $display("FAIL rr_pair_round%0d: got ok=%0d done=%0d left=%0d, expected 1 2 0",
                               round, ok, done_cnt, exp_q.size());
         end
      end
      // Pointer now sits at ch3: with ch2 parked in REQ, arm ch1 and ch3 behind it.
      clr_counts();
      bus.dreq1 = 1'b0; bus.dreq2 = 1'b1;
      hack_auto = 1'b0; bus.hack = 1'b0;
      cfg(2'd2, 8'd60, 8'd70, 8'd1);
      wait_hreq(1'b1, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rr_ch2_req: got hreq=%b, expected 1", bus.hreq); end
      bus.dreq1 = 1'b1;
      cfg(2'd1, 8'd80, 8'd90, 8'd1);
      cfg(2'd3, 8'd120, 8'd130, 8'd1);
      push_block(2'd2, 8'd60, 8'd70, 1);
      push_block(2'd3, 8'd120, 8'd130, 1);
      push_block(2'd1, 8'd80, 8'd90, 1);
      hack_auto = 1'b1;
      wait_quiet(150, ok);
      n_tests++;
      if (!ok || done_cnt !== 3) begin
         n_fail++; $display("FAIL rr_three: got ok=%0d done=%0d left=%0d, expected 1 3 0",
                            ok, done_cnt, exp_q.size());
      end
      bus.dreq1 = 1'b0; bus.dreq2 = 1'b0;
   endtask

   task automatic test_hack_drop();
      bit ok;
      clr_counts();
      hack_auto = 1'b0; bus.hack = 1'b0;
      rd_off = 8'h20;
      push_block(2'd3, 8'hFE, 8'h40, 4);   // source wraps FE, FF, 00, 01
      cfg(2'd3, 8'hFE, 8'h40, 8'd4);
      wait_hreq(1'b1, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL hd_req: got hreq=%b, expected 1", bus.hreq); end
      @(posedge clk);
      #1;
      bus.hack = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (rd_cnt >= 2) begin ok = 1'b1; break; end
      end
      bus.hack = 1'b0;                       // drops during the second word's read
      wait_hreq(1'b0, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL hd_release: got hreq=%b, expected 0", bus.hreq); end
      n_tests++;
      if (rd_cnt !== 2 || wr_cnt !== 2 || done_cnt !== 0) begin
         n_fail++; $display("FAIL hd_partial: got rd=%0d wr=%0d done=%0d, expected 2 2 0",
                            rd_cnt, wr_cnt, done_cnt);
      end
      wait_hreq(1'b1, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL hd_rearmed: got hreq=%b, expected 1", bus.hreq); end
      hack_auto = 1'b1;
      wait_quiet(100, ok);
      n_tests++;
      if (!ok || done_cnt !== 1 || rd_cnt !== 4) begin
         n_fail++; $display("FAIL hd_resume: got ok=%0d done=%0d rd=%0d, expected 1 1 4",
                            ok, done_cnt, rd_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic seen;
      clr_counts();
      hack_auto = 1'b1;
      rd_off = 8'h00;
      bus.dreq1 = 1'b1;
      push_block(2'd1, 8'd200, 8'd5, 3);
      cfg(2'd1, 8'd200, 8'd5, 8'd3);
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         #1;
         if (wr_cnt >= 2) begin ok = 1'b1; break; end
      end
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rm_reach_wr2: got %0d writes, expected 2", wr_cnt); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.hreq, bus.busy, bus.rd_mem, bus.wr_io, bus.en_mem, bus.en_io1} !== 6'b0) begin
         n_fail++; $display("FAIL rm_async: got hreq=%b busy=%b wr_io=%b en_io1=%b, expected 0 0 0 0",
                            bus.hreq, bus.busy, bus.wr_io, bus.en_io1);
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | bus.busy | bus.hreq;
      end
      n_tests++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_disarmed: got busy/hreq=%b, expected 0", seen); end
      bus.dreq1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ch1();
      test_ch2();
      test_ch3();
      test_round_robin();
      test_hack_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
